clic_sequencer: RTL and testbench

- Sequential front-end and sequencer for the can_clic priority-selection datapath.
- Captures interrupt edges into pending bits and holds per-source enable/priority configuration.
- Presents the winning source to the core over a req/ack handshake.
- Maintains a nested preemption-threshold stack that is pushed on ack and popped on handler return (done).
- Selection semantics match can_clic:
  - a candidate needs priority strictly greater than the current threshold;
  - on equal priority, the highest index wins.

---
 rtl/clic_sequencer.sv | 141 ++++++++++++++
 tb/tb_clic_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_sequencer.sv
// clic_sequencer: edge capture, source config, req/ack sequencer, threshold stack.
// Define CLIC_PREEMPT_EN to allow nested preemption up to DEPTH levels.
module clic_sequencer #(
    parameter int N_SRC  = 7,
    parameter int PRIO_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           irq_i,
    input  logic                       cfg_we,
    input  logic [$clog2(N_SRC)-1:0]   cfg_idx,
    input  logic                       cfg_en,
    input  logic [PRIO_W-1:0]          cfg_prio,
    input  logic                       ack_i,
    input  logic                       done_i,
    output logic                       req_o,
    output logic [$clog2(N_SRC)-1:0]   req_id_o,
    output logic [PRIO_W-1:0]          req_prio_o,
    output logic [PRIO_W-1:0]          thr_o,
    output logic [$clog2(DEPTH+1)-1:0] nest_o,
    output logic                       err_o
);
    localparam int IW = $clog2(N_SRC);
    localparam int NW = $clog2(DEPTH + 1);
`ifdef CLIC_PREEMPT_EN
    localparam int SD = DEPTH;
`else
    localparam int SD = 1;
`endif

    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;

    logic [N_SRC-1:0]  irq_q, pend_q, pend_d, en_q;
    logic [PRIO_W-1:0] prio_q  [N_SRC];
    logic [PRIO_W-1:0] stack_q [SD];
    logic [PRIO_W-1:0] thr_q, top;
    logic [NW-1:0]     nest_q;
    logic              err_q;

    logic              found;
    logic [IW-1:0]     win_id;
    logic [PRIO_W-1:0] win_prio;
    logic              issue, ack_ok, pop, cfg_ok, err_set;

    // Scanning upward with >= lets the highest index win ties.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pend_q[i] && en_q[i] && (prio_q[i] > thr_q) &&
                (!found || prio_q[i] >= win_prio)) begin
                found    = 1'b1;
                win_id   = IW'(i);
                win_prio = prio_q[i];
            end
        end
    end

    always_comb begin
        top = '0;
        for (int k = 0; k < SD; k++) begin
            if (nest_q == NW'(k + 1)) top = stack_q[k];
        end
    end

    assign ack_ok  = ack_i && (state_q == REQ);
    assign pop     = done_i && (nest_q != '0);
    assign cfg_ok  = {1'b0, cfg_idx} < (IW+1)'(N_SRC);
    assign issue   = (state_q == IDLE) && found && (nest_q < NW'(SD));
    assign err_set = (ack_i && !ack_ok) || (done_i && !pop) ||
                     (cfg_we && !cfg_ok);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (issue) state_d = REQ;
            REQ:  if (ack_i) state_d = IDLE;
        endcase
    end

    // A fresh edge on the acked source wins over its clear.
    always_comb begin
        pend_d = pend_q;
        if (ack_ok) pend_d[req_id_o] = 1'b0;
        pend_d = pend_d | (irq_i & ~irq_q);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q      <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            thr_q      <= '0;
            nest_q     <= '0;
            err_q      <= 1'b0;
            req_id_o   <= '0;
            req_prio_o <= '0;
            for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
            for (int k = 0; k < SD; k++) stack_q[k] <= '0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;
            if (cfg_we && cfg_ok) begin
                en_q[cfg_idx]   <= cfg_en;
                prio_q[cfg_idx] <= cfg_prio;
            end
            if (issue) begin
                req_id_o   <= win_id;
                req_prio_o <= win_prio;
            end
            if (err_set) err_q <= 1'b1;
            // With a same-cycle pop, the restored thr is re-pushed in place.
            if (ack_ok) begin
                thr_q <= req_prio_o;
                if (!pop) begin
                    for (int k = 0; k < SD; k++) begin
                        if (nest_q == NW'(k)) stack_q[k] <= thr_q;
                    end
                    nest_q <= nest_q + 1'b1;
                end
            end else if (pop) begin
                thr_q  <= top;
                nest_q <= nest_q - 1'b1;
            end
        end
    end

    assign req_o  = (state_q == REQ);
    assign thr_o  = thr_q;
    assign nest_o = nest_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_clic_sequencer.sv
// Scoreboard bench for clic_sequencer: behavioural model predicts requests,
// threshold, nesting and error; a negedge monitor compares.
module tb_clic_sequencer;
    localparam int N    = 7;
    localparam int PMAX = 3;
`ifdef CLIC_PREEMPT_EN
    localparam int MAXD = 4;
`else
    localparam int MAXD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] irq_i = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic       cfg_en = 1'b0;
    logic [1:0] cfg_prio = '0;
    logic       ack_i = 1'b0;
    logic       done_i = 1'b0;
    logic       req_o;
    logic [2:0] req_id_o;
    logic [1:0] req_prio_o;
    logic [1:0] thr_o;
    logic [2:0] nest_o;
    logic       err_o;

    clic_sequencer dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_prio(cfg_prio),
        .ack_i(ack_i), .done_i(done_i), .req_o(req_o),
        .req_id_o(req_id_o), .req_prio_o(req_prio_o), .thr_o(thr_o),
        .nest_o(nest_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    bit [6:0] m_pend, m_en, m_irqq;
    int       m_prio [N];
    int       m_stack[$];
    int       m_thr, m_id, m_lprio;
    bit       m_inreq, m_err;
    int       exp_q[$];

    always @(posedge clk) begin : model
        int w, wp;
        bit ackv;
        if (rst) begin
            m_pend = '0; m_en = '0; m_irqq = '0;
            for (int i = 0; i < N; i++) m_prio[i] = 0;
            m_stack.delete();
            m_thr = 0; m_inreq = 0; m_err = 0; m_id = 0; m_lprio = 0;
        end else begin
            w = -1; wp = 0;
            if (!m_inreq && m_stack.size() < MAXD)
                for (int p = PMAX; p > m_thr && w < 0; p--)
                    for (int i = N - 1; i >= 0 && w < 0; i--)
                        if (m_pend[i] && m_en[i] && m_prio[i] == p) begin
                            w = i; wp = p;
                        end
            if (cfg_we) begin
                if (cfg_idx < N) begin
                    m_en[cfg_idx] = cfg_en;
                    m_prio[cfg_idx] = cfg_prio;
                end else m_err = 1;
            end
            ackv = ack_i && m_inreq;
            if (ack_i && !m_inreq) m_err = 1;
            if (done_i) begin
                if (m_stack.size() > 0) m_thr = m_stack.pop_back();
                else m_err = 1;
            end
            if (ackv) begin
                m_pend[m_id] = 0;
                m_stack.push_back(m_thr);
                m_thr = m_lprio;
                m_inreq = 0;
            end
            m_pend = m_pend | (irq_i & ~m_irqq);
            m_irqq = irq_i;
            if (w >= 0) begin
                m_inreq = 1; m_id = w; m_lprio = wp;
                exp_q.push_back(w * 16 + wp);
            end
        end
    end

    bit prev_req = 1'b0;
    always @(negedge clk) begin : monitor
        int e;
        if (mon_en) begin
            chk("req_o", int'(req_o), int'(m_inreq));
            chk("thr_o", int'(thr_o), m_thr);
            chk("nest_o", int'(nest_o), m_stack.size());
            chk("err_o", int'(err_o), int'(m_err));
            if (req_o && !prev_req) begin
                if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("req_id", int'(req_id_o), e / 16);
                    chk("req_prio", int'(req_prio_o), e % 16);
                end
            end else if (req_o) begin
                chk("req_id_stable", int'(req_id_o), m_id);
                chk("req_prio_stable", int'(req_prio_o), m_lprio);
            end
            prev_req = req_o;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg(int idx, bit en, int p);
        cfg_we = 1; cfg_idx = 3'(idx); cfg_en = en; cfg_prio = 2'(p);
        step();
        cfg_we = 0;
    endtask

    task automatic irq(logic [6:0] m);
        irq_i = m;
        step();
        irq_i = '0;
    endtask

    task automatic do_done();
        done_i = 1;
        step();
        done_i = 0;
    endtask

    task automatic do_ack(bit with_done);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_o) got = 1;
            else step();
        end
        if (!got) chk("req_wait", int'(req_o), int'(m_inreq));
        else begin
            ack_i = 1; done_i = with_done;
            step();
            ack_i = 0; done_i = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (req_o) begin
                ack_i = 1; step(); ack_i = 0;
            end else if (nest_o != 0) do_done();
            else step();
        end
    endtask

    initial begin
        rst = 1;
        step();
        mon_en = 1;
        step();
        rst = 0;
        chk("rst_req_id", int'(req_id_o), 0);
        chk("rst_req_prio", int'(req_prio_o), 0);

        // tie-break and latency
        cfg(0, 1, 1); cfg(3, 1, 1); cfg(4, 1, 1);
        irq(7'b0011001);
        chk("lat_before", int'(req_o), 0);
        step();
        chk("lat_req", int'(req_o), 1);
        chk("tie_id", int'(req_id_o), 4);
        chk("tie_prio", int'(req_prio_o), 1);
        drain();

        // threshold filter
        cfg(2, 1, 1);
        irq(7'b0000100);
        do_ack(0);
        irq(7'b0001000);
        repeat (4) step();
        chk("thr_block", int'(req_o), 0);
        do_done();
        step();
        chk("thr_release", int'(req_o), 1);
        chk("thr_release_id", int'(req_id_o), 3);
        drain();

        // stable request
        cfg(1, 1, 1); cfg(6, 1, 3);
        irq(7'b0000010);
        step();
        irq(7'b1000000);
        repeat (3) step();
        chk("stable_id", int'(req_id_o), 1);
        drain();

`ifdef CLIC_PREEMPT_EN
        // preemption
        cfg(5, 1, 3);
        irq(7'b0000100);
        do_ack(0);
        irq(7'b0100000);
        do_ack(0);
        chk("pre_nest", int'(nest_o), 2);
        chk("pre_thr", int'(thr_o), 3);
        do_done();
        chk("pre_thr1", int'(thr_o), 1);
        do_done();
        chk("pre_thr0", int'(thr_o), 0);
        drain();
        // simultaneous ack and done
        cfg(0, 1, 2); cfg(4, 1, 3);
        irq(7'b0000001);
        do_ack(0);
        irq(7'b0010000);
        do_ack(1);
        chk("ad_nest", int'(nest_o), 1);
        chk("ad_thr", int'(thr_o), 3);
        drain();
`endif

        // errors and reset
        do_done();
        chk("err_done", int'(err_o), 1);
        irq(7'b1000000);
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_req", int'(req_o), 0);
        chk("rst_err", int'(err_o), 0);
        repeat (4) step();

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            irq_i = irq_i ^ (7'($urandom) & 7'($urandom) & 7'($urandom));
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_idx = ($urandom_range(0, 63) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            cfg_en = ($urandom_range(0, 3) != 0);
            cfg_prio = 2'($urandom);
            ack_i = req_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
            done_i = (nest_o != 0) ? ($urandom_range(0, 5) == 0)
                                   : ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; irq_i = '0; cfg_we = 0; ack_i = 0; done_i = 0;
        drain();
        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
